// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter for the fetch (I) and data (D) requesters.
// One access at a time: IDLE grants, BUSY waits for mem_ready (or the
// watchdog), RESP pulses the owner's done for one cycle, then back to IDLE.
//
// Handshake: a requester raises req and holds it, with address and data
// stable, until its done pulse. done is high for exactly one cycle. The
// pipeline advances on the edge that ends that cycle. On the memory side,
// mem_valid/mem_we/mem_addr/mem_wdata are stable while mem_valid is high.
// Memory finishes the access in the cycle it raises mem_ready, and mem_rdata
// must be valid in that same cycle. mem_ready is ignored when mem_valid is low.
module mem_port_arbiter #(
    parameter int          MAX_D_STREAK = 4,
    parameter int          TIMEOUT      = 64,
    parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        StallI,
    output logic        StallM,
    output logic        timeout_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [WW-1:0] WD_LAST    = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;          // 1 = D owns the port, 0 = I
    logic [SW-1:0] streak_q, streak_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic          timeout_err_q, timeout_err_d;
    logic          busy_end;

    // Next-state logic: grant, memory wait with watchdog, single-cycle response.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        streak_d      = streak_q;
        wd_d          = wd_q;
        mem_valid_d   = mem_valid_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        timeout_err_d = timeout_err_q;
        i_done_d      = 1'b0;
        d_done_d      = 1'b0;
        busy_end      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // D has priority unless it has used up its streak while I waits.
                if (d_req && !(i_req && streak_q == STREAK_MAX)) begin
                    owner_d     = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_valid_d = 1'b1;
                    wd_d        = '0;
                    state_d     = S_BUSY;
                    if (!i_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (i_req) begin
                    owner_d     = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    mem_valid_d = 1'b1;
                    wd_d        = '0;
                    streak_d    = '0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    if (!owner_q) begin
                        i_rdata_d = mem_rdata;
                    end else if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    busy_end = 1'b1;
                end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
                    // Memory never answered: return a recognisable error word.
                    timeout_err_d = 1'b1;
                    if (!owner_q) begin
                        i_rdata_d = ERR_DATA;
                    end else if (!mem_we_q) begin
                        d_rdata_d = ERR_DATA;
                    end
                    busy_end = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
                if (busy_end) begin
                    mem_valid_d = 1'b0;
                    mem_we_d    = 1'b0;
                    i_done_d    = ~owner_q;
                    d_done_d    = owner_q;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                // No re-arbitration here, so a still-high req is not granted twice.
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                mem_valid_d = 1'b0;
                mem_we_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b0;
            streak_q      <= '0;
            wd_q          <= '0;
            mem_valid_q   <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            i_done_q      <= 1'b0;
            d_done_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            streak_q      <= streak_d;
            wd_q          <= wd_d;
            mem_valid_q   <= mem_valid_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            i_done_q      <= i_done_d;
            d_done_q      <= d_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_valid   = mem_valid_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign i_done      = i_done_q;
    assign d_done      = d_done_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;
    assign StallI      = i_req & ~i_done_q;
    assign StallM      = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed requester scenarios, a simple memory
// responder with programmable latency, and two scoreboard monitors (memory
// side and completion side) fed from expected queues.
module tb_mem_port_arbiter;

    localparam int MAX_D = 4;
    localparam int TMO   = 8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_done, d_done, mem_valid, mem_we, StallI, StallM, timeout_err;
    logic [1:0]  dbg_state;

    mem_port_arbiter #(.MAX_D_STREAK(MAX_D), .TIMEOUT(TMO), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .StallI(StallI), .StallM(StallM), .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] exp_q[$];      // {is_d, rdata seen at done}
    logic [65:0] exp_mem_q[$];  // {check_wdata, we, addr, wdata}
    int          mem_lat = 0;   // BUSY cycles before mem_ready; <0 = never
    logic        force_ready = 1'b0;
    int          last_valid_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h100) ? 32'h8C080004 : {16'hC0DE, a[15:0]};
    endfunction

    // ---------------- memory responder ----------------
    int busy_cnt = 0;
    always @(negedge clk) begin
        if (mem_valid) begin
            if (mem_lat >= 0 && busy_cnt == mem_lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_model(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0BAD0;
            end
            busy_cnt++;
        end else begin
            mem_ready = force_ready;
            mem_rdata = 32'hBAD0BAD0;
            busy_cnt  = 0;
        end
    end

    // ---------------- memory-side monitor ----------------
    logic        prev_valid = 1'b0;
    logic [65:0] cur_mem;
    logic [64:0] held;
    int          vlen = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
            vlen       = 0;
        end else begin
            if (mem_valid && !prev_valid) begin
                vlen = 1;
                chk("mem_expected", exp_mem_q.size() != 0, 1);
                if (exp_mem_q.size() != 0) begin
                    cur_mem = exp_mem_q.pop_front();
                    chk("mem_we", mem_we, cur_mem[64]);
                    chk("mem_addr", mem_addr, cur_mem[63:32]);
                    if (cur_mem[65]) chk("mem_wdata", mem_wdata, cur_mem[31:0]);
                end
                held = {mem_we, mem_addr, mem_wdata};
            end else if (mem_valid) begin
                vlen++;
                chk("mem_hold", {mem_we, mem_addr, mem_wdata} == held, 1);
            end else if (prev_valid) begin
                last_valid_len = vlen;
            end
            prev_valid = mem_valid;
        end
    end

    // ---------------- completion monitor ----------------
    logic        prev_i = 1'b0, prev_d = 1'b0;
    logic [32:0] cur_exp;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_i = 1'b0;
            prev_d = 1'b0;
        end else begin
            if (i_done || d_done) begin
                chk("done_excl", i_done & d_done, 0);
                chk("valid_in_resp", mem_valid, 0);
                chk("done_width", (i_done & prev_i) | (d_done & prev_d), 0);
                chk("done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur_exp = exp_q.pop_front();
                    chk("done_owner", d_done, cur_exp[32]);
                    chk(d_done ? "d_rdata" : "i_rdata", d_done ? d_rdata : i_rdata, cur_exp[31:0]);
                end
            end
            prev_i = i_done;
            prev_d = d_done;
        end
    end

    // ---------------- driver ----------------
    task automatic run_req(input logic is_d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int stall);
        bit got = 0;
        if (is_d) begin
            d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            i_addr = addr; i_req = 1'b1;
        end
        #1;
        stall = (is_d ? StallM : StallI) ? 1 : 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (is_d ? d_done : i_done) begin
                got = 1;
                break;
            end
            if (is_d ? StallM : StallI) stall++;
        end
        chk(is_d ? "d_done_seen" : "i_done_seen", got, 1);
        if (got) chk("stall_low_at_done", is_d ? StallM : StallI, 0);
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    int st_i, st_d;
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", mem_valid, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_done", {i_done, d_done}, 0);
        chk("rst_err", timeout_err, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_state", dbg_state, 0);
        chk("idle_stall", {StallI, StallM}, 0);

        // Single fetch, ready on first BUSY cycle.
        mem_lat = 0;
        exp_mem_q.push_back({1'b0, 1'b0, 32'h100, 32'h0});
        exp_q.push_back({1'b0, 32'h8C080004});
        run_req(1'b0, 1'b0, 32'h100, 32'h0, st_i);
        chk("t1_stall", st_i, 2);
        @(negedge clk);
        chk("t1_valid_len", last_valid_len, 1);

        // Simultaneous: D store first, then I.
        exp_mem_q.push_back({1'b1, 1'b1, 32'h200, 32'h55});
        exp_mem_q.push_back({1'b0, 1'b0, 32'h104, 32'h0});
        exp_q.push_back({1'b1, 32'h0});
        exp_q.push_back({1'b0, 32'hC0DE0104});
        fork
            run_req(1'b1, 1'b1, 32'h200, 32'h55, st_d);
            run_req(1'b0, 1'b0, 32'h104, 32'h0, st_i);
        join
        chk("t2_stall_d", st_d, 2);
        chk("t2_stall_i", st_i, 5);
        @(negedge clk);

        // Starvation bound: D,D,D,D,I,D.
        for (int k = 0; k < 4; k++) begin
            exp_mem_q.push_back({1'b0, 1'b0, 32'h300 + 32'(4 * k), 32'h0});
            exp_q.push_back({1'b1, 32'hC0DE0300 + 32'(4 * k)});
        end
        exp_mem_q.push_back({1'b0, 1'b0, 32'h400, 32'h0});
        exp_q.push_back({1'b0, 32'hC0DE0400});
        exp_mem_q.push_back({1'b0, 1'b0, 32'h310, 32'h0});
        exp_q.push_back({1'b1, 32'hC0DE0310});
        fork
            run_req(1'b0, 1'b0, 32'h400, 32'h0, st_i);
            begin
                for (int k = 0; k < 5; k++)
                    run_req(1'b1, 1'b0, 32'h300 + 32'(4 * k), 32'h0, st_d);
            end
        join
        @(negedge clk);

        // Variable latency: 5 wait cycles on a store.
        mem_lat = 5;
        exp_mem_q.push_back({1'b1, 1'b1, 32'h600, 32'hA5A55A5A});
        exp_q.push_back({1'b1, 32'hC0DE0310});
        run_req(1'b1, 1'b1, 32'h600, 32'hA5A55A5A, st_d);
        chk("t4_stall", st_d, 7);
        @(negedge clk);
        chk("t4_valid_len", last_valid_len, 6);

        // Stray mem_ready while idle must be ignored.
        force_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_valid", mem_valid, 0);
            chk("stray_state", dbg_state, 0);
        end
        force_ready = 1'b0;
        chk("stray_i_rdata", i_rdata, 32'hC0DE0400);

        // Watchdog timeout on a load.
        chk("t5_err_before", timeout_err, 0);
        mem_lat = -1;
        exp_mem_q.push_back({1'b0, 1'b0, 32'h500, 32'h0});
        exp_q.push_back({1'b1, 32'hDEADBEEF});
        run_req(1'b1, 1'b0, 32'h500, 32'h0, st_d);
        chk("t5_stall", st_d, 9);
        @(negedge clk);
        chk("t5_err", timeout_err, 1);
        chk("t5_valid_len", last_valid_len, 8);
        mem_lat = 0;
        exp_mem_q.push_back({1'b0, 1'b0, 32'h108, 32'h0});
        exp_q.push_back({1'b0, 32'hC0DE0108});
        run_req(1'b0, 1'b0, 32'h108, 32'h0, st_i);
        @(negedge clk);
        chk("t5_err_sticky", timeout_err, 1);

        // Reset in the middle of a BUSY access.
        mem_lat = -1;
        exp_mem_q.push_back({1'b0, 1'b0, 32'h700, 32'h0});
        d_we = 1'b0; d_addr = 32'h700; d_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_busy", mem_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_valid", mem_valid, 0);
        chk("t6_done", d_done, 0);
        chk("t6_err", timeout_err, 0);
        chk("t6_d_rdata", d_rdata, 0);
        chk("t6_state", dbg_state, 0);
        d_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t6_idle_valid", mem_valid, 0);
            chk("t6_idle_state", dbg_state, 0);
        end
        mem_lat = 0;
        exp_mem_q.push_back({1'b0, 1'b0, 32'h10C, 32'h0});
        exp_q.push_back({1'b0, 32'hC0DE010C});
        run_req(1'b0, 1'b0, 32'h10C, 32'h0, st_i);
        chk("t6_stall", st_i, 2);

        repeat (3) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("exp_mem_q_empty", exp_mem_q.size(), 0);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates a single shared memory port between the instruction-fetch requester (I) and the data-memory stage requester (D) of the pipelined core. Grants one requester at a time through a registered request/ready handshake with variable memory latency. Generates the fetch- and memory-stage stall signals that feed the hazard unit, with a bounded-starvation fairness rule and a watchdog timeout.

Parameters:
MAX_D_STREAK, 4, consecutive D grants allowed while i_req is pending before I is forced a grant (>=1)
TIMEOUT, 64, BUSY cycles without mem_ready before abort; 0 disables the watchdog
ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out access

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
i_req  in  1  fetch request; held high until i_done
i_addr  in  32  fetch address
i_rdata  out  32  fetched instruction (registered)
i_done  out  1  one-cycle completion pulse for I
d_req  in  1  data request; held high until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data address
d_wdata  in  32  store data
d_rdata  out  32  load data (registered)
d_done  out  1  one-cycle completion pulse for D
mem_valid  out  1  access in progress to memory
mem_we  out  1  write strobe, valid with mem_valid
mem_addr  out  32  registered address
mem_wdata  out  32  registered write data
mem_rdata  in  32  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current access this cycle
StallI  out  1  i_req & ~i_done (combinational)
StallM  out  1  d_req & ~d_done (combinational)
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous and active-low.
- Reset (asynchronous, any state, including mid-access): state=IDLE; mem_valid, mem_we, i_done, d_done, timeout_err = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0; streak and watchdog counters = 0.
- States: IDLE, BUSY, RESP. Owner register (I/D) is set on grant.
- IDLE: with no request, stay. Otherwise grant by priority:
  - D is granted if d_req & ~(i_req & streak==MAX_D_STREAK).
  - Otherwise, if i_req, I is granted.
  - On grant, latch addr/wdata/we (we forced to 0 for I) and go to BUSY.
  - A D grant increments streak (saturating at MAX_D_STREAK); an I grant clears streak. A D grant with i_req low also clears streak.
- BUSY: mem_valid=1; mem_addr, mem_wdata and mem_we are held stable.
  - mem_ready=1: capture mem_rdata into the owner's rdata register. Loads and fetches only; a store leaves d_rdata unchanged. Go to RESP.
  - Otherwise, when TIMEOUT!=0 and the watchdog count reaches TIMEOUT-1, abort: set timeout_err, load ERR_DATA into the owner's rdata (loads and fetches only), go to RESP.
  - The watchdog counter clears on entering BUSY.
- RESP: mem_valid=0. Owner's done=1 for exactly this cycle; the pipeline advances on this edge. Always go to IDLE; there is no re-arbitration in RESP, so a still-high req is never granted twice.
- Latency: request seen in IDLE at cycle 0; mem_valid at cycle 1; mem_ready at cycle 1 gives done at cycle 2. Minimum of 2 stall cycles per access, 3 cycles per access.
- mem_ready outside BUSY is ignored.
- A requester dropping req before done is a protocol violation. The access still completes and done still pulses.
- timeout_err clears only on reset.
- i_done and d_done are never high together. mem_valid is never high in IDLE or RESP.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100; mem_ready on the first BUSY cycle with rdata 0x8C080004 -> mem_valid at cycle 1 with mem_addr 0x100, mem_we 0; i_done and i_rdata=0x8C080004 at cycle 2; StallI high for cycles 0-1 only.
- Simultaneous requests: i_req=d_req=1, store to 0x200 with data 0x55 -> D served first (mem_we=1, mem_wdata=0x55); d_done fires and d_rdata is unchanged; I is then granted from the next IDLE.
- Starvation bound: MAX_D_STREAK=4; d_req and i_req held high and d_req re-raised after each done -> grant order D,D,D,D,I,D,...; the I grant follows the 4th D completion.
- Variable latency: memory stalls 5 cycles before mem_ready -> mem_valid high for 6 consecutive cycles with stable addr/wdata; done exactly 1 cycle; total stall 7 cycles.
- Timeout: TIMEOUT=8, mem_ready never asserted on a load -> after 8 BUSY cycles d_done pulses, d_rdata=0xDEADBEEF, timeout_err=1 and stays high through later normal accesses.
- Reset mid-access: reset_n low during BUSY -> mem_valid, done and timeout_err drop immediately without a clock edge; after release, an idle bench stays in IDLE and a new request completes normally.
